minc_trace_buffer: RTL and testbench

Synthesisable, parametrised PC/ACC trace capture for the minc core. Replaces the fixed 64-cycle monitor loop with an on-chip ring buffer. Supports an arm/trigger/post-trigger sequence (immediate or PC-match trigger) and drains captured samples oldest-first over a valid/ready port. Sits beside the core, fed directly from pc_out/acc_out.

---
 rtl/minc_trace_pkg.sv | 14 +
 rtl/minc_trace_buffer_if.sv | 14 +
 rtl/minc_trace_mem.sv | 23 ++
 rtl/minc_trace_buffer.sv | 161 ++++++++++++++++
 tb/tb_minc_trace_buffer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/minc_trace_pkg.sv
// Shared encodings for the minc PC/ACC trace buffer.
package minc_trace_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } trace_state_e;

  localparam logic TrigImmediate = 1'b0;
  localparam logic TrigPc        = 1'b1;

endpackage

// File: rtl/minc_trace_buffer_if.sv
// Readout valid/ready port of the trace buffer; the buffer is the master.
interface minc_trace_buffer_if #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned ACC_W = 8
);
  logic             rd_valid;
  logic             rd_ready;
  logic [PC_W-1:0]  rd_pc;
  logic [ACC_W-1:0] rd_acc;
  logic             rd_last;

  modport master (output rd_valid, output rd_pc, output rd_acc, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_pc, input rd_acc, input rd_last, output rd_ready);
endinterface

// File: rtl/minc_trace_mem.sv
// Trace storage: synchronous write, asynchronous read, contents not reset.
module minc_trace_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned W     = 24,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/minc_trace_buffer.sv
// PC/ACC ring-buffer trace capture with arm/trigger/post-trigger sequencing
// and oldest-first readout over a valid/ready port.
module minc_trace_buffer
  import minc_trace_pkg::*;
#(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic               sample_en,
  input  logic               arm,
  input  logic               abort,
  input  logic               trig_mode,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [CNT_W-1:0]   post_count,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  minc_trace_buffer_if.master rd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned W  = PC_W + ACC_W;
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MaxPost = CNT_W'(DEPTH - 1);

  trace_state_e     state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, remaining_q, remaining_d;
  logic [CNT_W-1:0] rd_left_q, rd_left_d, post_q, post_d;
  logic             overflow_q, overflow_d, trig_mode_q, trig_mode_d;
  logic [PC_W-1:0]  trig_pc_q, trig_pc_d;
  logic             wr_en, trig_hit, rd_valid, rd_xfer;
  logic [W-1:0]     rd_data;

  assign rd_valid = (state_q == StDone) && (rd_left_q != '0);
  assign rd_xfer  = rd_valid && rd.rd_ready;
  assign trig_hit = (trig_mode_q == TrigImmediate) || (pc_in == trig_pc_q);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    rd_left_d   = rd_left_q;
    post_d      = post_q;
    overflow_d  = overflow_q;
    trig_mode_d = trig_mode_q;
    trig_pc_d   = trig_pc_q;
    wr_en       = 1'b0;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            trig_mode_d = trig_mode;
            trig_pc_d   = trig_pc;
            post_d      = (post_count > MaxPost) ? MaxPost : post_count;
            wr_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            state_d     = StArmed;
          end
        end
        StArmed: begin
          if (sample_en) begin
            wr_en = 1'b1;
            if (trig_hit) begin
              remaining_d = post_q;
              state_d     = (post_q == '0) ? StDone : StCapture;
            end
          end
        end
        StCapture: begin
          if (sample_en) begin
            wr_en       = 1'b1;
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) state_d = StDone;
          end
        end
        StDone: begin
          if (rd_xfer) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_left_d = rd_left_q - CNT_W'(1);
            if (rd_left_q == CNT_W'(1)) state_d = StIdle;
          end else if (rd_left_q == '0) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q == FullCnt) overflow_d = 1'b1;
      else                    count_d    = count_q + CNT_W'(1);
    end

    // Readout setup uses the post-write pointer/count so the final sample is included.
    if ((state_q != StDone) && (state_d == StDone)) begin
      rd_ptr_d  = overflow_d ? wr_ptr_d : '0;
      rd_left_d = count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      rd_left_q   <= '0;
      post_q      <= '0;
      overflow_q  <= 1'b0;
      trig_mode_q <= TrigImmediate;
      trig_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      rd_left_q   <= rd_left_d;
      post_q      <= post_d;
      overflow_q  <= overflow_d;
      trig_mode_q <= trig_mode_d;
      trig_pc_q   <= trig_pc_d;
    end
  end

  minc_trace_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .CLK   (CLK),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({pc_in, acc_in}),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd.rd_valid = rd_valid;
  assign rd.rd_pc    = rd_data[W-1:ACC_W];
  assign rd.rd_acc   = rd_data[ACC_W-1:0];
  assign rd.rd_last  = rd_valid && (rd_left_q == CNT_W'(1));
  assign state       = state_q;
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_minc_trace_buffer.sv
// Self-checking bench: a queue-based model of the capture/readout rules is
// compared against the DUT every cycle; directed scenarios pin it with literals.
module tb_minc_trace_buffer;

  localparam int PC_W  = 16;
  localparam int ACC_W = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int W     = PC_W + ACC_W;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [PC_W-1:0]  pc_in = '0;
  logic [ACC_W-1:0] acc_in = '0;
  logic             sample_en = 1'b0, arm = 1'b0, abort = 1'b0, trig_mode = 1'b0;
  logic [PC_W-1:0]  trig_pc = '0;
  logic [CNT_W-1:0] post_count = '0;
  logic [1:0]       st;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  minc_trace_buffer_if #(.PC_W(PC_W), .ACC_W(ACC_W)) rd_if ();

  minc_trace_buffer #(
    .PC_W(PC_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .pc_in(pc_in), .acc_in(acc_in), .sample_en(sample_en),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_pc(trig_pc),
    .post_count(post_count), .state(st), .count(cnt), .overflow(ovf), .rd(rd_if)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: every stored sample in order, readout = newest DEPTH of them.
  int           m_state = 0;
  int           m_n = 0;
  int           m_post = 0;
  int           m_rem = 0;
  logic         m_mode = 1'b0;
  logic [15:0]  m_tpc = '0;
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_rd[$];

  task automatic m_store();
    m_hist.push_back({pc_in, acc_in});
    if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
    m_n++;
  endtask

  task automatic m_enter_done();
    m_rd    = m_hist;
    m_state = 3;
  endtask

  task automatic model_step();
    if (RESET) begin
      m_state = 0; m_n = 0; m_hist.delete(); m_rd.delete();
    end else if (abort) begin
      m_state = 0; m_rd.delete();
    end else begin
      case (m_state)
        0: if (arm) begin
          m_mode = trig_mode; m_tpc = trig_pc;
          m_post = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
          m_n = 0; m_hist.delete(); m_state = 1;
        end
        1: if (sample_en) begin
          m_store();
          if (m_mode == 1'b0 || pc_in == m_tpc) begin
            m_rem = m_post;
            if (m_rem == 0) m_enter_done();
            else m_state = 2;
          end
        end
        2: if (sample_en) begin
          m_store();
          m_rem--;
          if (m_rem == 0) m_enter_done();
        end
        default: if (rd_if.rd_ready && m_rd.size() > 0) begin
          void'(m_rd.pop_front());
          if (m_rd.size() == 0) m_state = 0;
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      bit ev;
      ev = (m_state == 3) && (m_rd.size() > 0);
      check("state", 32'(st), 32'(m_state));
      check("count", 32'(cnt), 32'((m_n > DEPTH) ? DEPTH : m_n));
      check("overflow", 32'(ovf), 32'(m_n > DEPTH));
      check("rd_valid", 32'(rd_if.rd_valid), 32'(ev));
      check("rd_last", 32'(rd_if.rd_last), 32'(ev && m_rd.size() == 1));
      if (ev) begin
        check("rd_pc", 32'(rd_if.rd_pc), 32'(m_rd[0][W-1:ACC_W]));
        check("rd_acc", 32'(rd_if.rd_acc), 32'(m_rd[0][ACC_W-1:0]));
      end
    end
  end

  // Collects every accepted beat for the directed literal checks.
  logic [PC_W-1:0] got_pc[$];
  bit              got_last[$];
  initial forever begin
    @(negedge CLK);
    if (rd_if.rd_valid === 1'b1 && rd_if.rd_ready === 1'b1) begin
      got_pc.push_back(rd_if.rd_pc);
      got_last.push_back(rd_if.rd_last);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_arm(input logic mode, input int tpc, input int post);
    arm = 1'b1; trig_mode = mode; trig_pc = PC_W'(tpc); post_count = CNT_W'(post);
    tick();
    arm = 1'b0;
  endtask

  task automatic feed(input int base, input int n, input bit alternate);
    for (int i = 0; i < n; i++) begin
      pc_in = PC_W'(base + i);
      acc_in = ACC_W'($urandom);
      sample_en = alternate ? (i % 2 == 0) : 1'b1;
      tick();
    end
    sample_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    got_pc.delete(); got_last.delete();
    rd_if.rd_ready = 1'b1;
    while (st !== 2'd0 && k < budget) begin
      tick();
      k++;
    end
    rd_if.rd_ready = 1'b0;
    check("drain_to_idle", 32'(st), 32'd0);
  endtask

  task automatic check_got(input string nm, input int base, input int step, input int n);
    check({nm, "_beats"}, 32'(got_pc.size()), 32'(n));
    for (int i = 0; i < n && i < got_pc.size(); i++) begin
      check({nm, "_pc"}, 32'(got_pc[i]), 32'(base + i * step));
      check({nm, "_last"}, 32'(got_last[i]), 32'(i == n - 1));
    end
  endtask

  task automatic check_top(input string nm, input int s, input int c, input int o);
    check({nm, "_state"}, 32'(st), 32'(s));
    check({nm, "_count"}, 32'(cnt), 32'(c));
    check({nm, "_overflow"}, 32'(ovf), 32'(o));
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    RESET = 1'b0;
    check_top("reset", 0, 0, 0);
    check("reset_rd_valid", 32'(rd_if.rd_valid), 32'd0);

    // Immediate trigger, three post samples.
    do_arm(1'b0, 0, 3);
    feed(16'h100, 10, 1'b0);
    check_top("imm", 3, 4, 0);
    drain(20);
    check_got("imm", 16'h100, 1, 4);

    // PC-match trigger with wrap: oldest pre-trigger history overwritten.
    do_arm(1'b1, 16'h0C, 2);
    feed(16'h00, 20, 1'b0);
    check_top("pcmatch", 3, 8, 1);
    drain(20);
    check_got("pcmatch", 16'h07, 1, 8);

    // Gapped sample_en during capture.
    do_arm(1'b0, 0, 3);
    feed(16'h200, 10, 1'b1);
    check_top("gapped", 3, 4, 0);
    drain(20);
    check_got("gapped", 16'h200, 2, 4);

    // Readout stall holds the head beat.
    do_arm(1'b0, 0, 5);
    feed(16'h300, 6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_pc", 32'(rd_if.rd_pc), 32'h300);
      tick();
    end
    drain(20);
    check_got("stall", 16'h300, 1, 6);

    // arm ignored mid-capture, abort returns to IDLE keeping count.
    do_arm(1'b0, 0, 10);
    feed(16'h400, 3, 1'b0);
    arm = 1'b1; tick(); arm = 1'b0;
    check("arm_in_capture", 32'(st), 32'd2);
    abort = 1'b1; sample_en = 1'b1; pc_in = 16'h4FF; tick();
    abort = 1'b0; sample_en = 1'b0;
    check_top("abort", 0, 3, 0);
    check("abort_rd_valid", 32'(rd_if.rd_valid), 32'd0);

    // post_count clamps to DEPTH-1; arm ignored in DONE.
    do_arm(1'b0, 0, 15);
    feed(16'h500, 20, 1'b0);
    check_top("clamp", 3, 8, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    check("arm_in_done", 32'(st), 32'd3);
    drain(20);
    check_got("clamp", 16'h500, 1, 8);

    // RESET on the third readout beat, then a fresh capture.
    do_arm(1'b0, 0, 5);
    feed(16'h600, 6, 1'b0);
    rd_if.rd_ready = 1'b1; tick(); tick();
    check("third_beat_pc", 32'(rd_if.rd_pc), 32'h602);
    RESET = 1'b1; tick(); RESET = 1'b0; rd_if.rd_ready = 1'b0;
    check_top("midread_reset", 0, 0, 0);
    check("midread_rd_valid", 32'(rd_if.rd_valid), 32'd0);
    do_arm(1'b1, 16'h703, 1);
    feed(16'h700, 8, 1'b0);
    check_top("after_reset", 3, 5, 0);
    drain(20);
    check_got("after_reset", 16'h700, 1, 5);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      RESET = ($urandom_range(0, 399) == 0);
      abort = ($urandom_range(0, 99) == 0);
      arm = ($urandom_range(0, 9) == 0);
      sample_en = ($urandom_range(0, 2) != 0);
      pc_in = PC_W'($urandom_range(0, 15));
      acc_in = ACC_W'($urandom);
      trig_mode = 1'($urandom);
      trig_pc = PC_W'($urandom_range(0, 15));
      post_count = CNT_W'($urandom_range(0, 15));
      rd_if.rd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    RESET = 1'b0; abort = 1'b0; arm = 1'b0; sample_en = 1'b0; rd_if.rd_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
